count_jump_arbiter: RTL and testbench



---
 rtl/count_jump_arbiter.sv | 162 ++++++++++++++++
 tb/tb_count_jump_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_jump_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : count_jump_arbiter
// Description : Free-running WIDTH-bit up-counter with a single jump-load
//               path shared round-robin among NREQ requesters. A requester
//               holds req[i] high with a target in its jval slice. Each
//               assertion of req[i] produces exactly one load. The block
//               then waits for req[i] to drop before it arbitrates again.
//
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               ce       - count enable; gates only the out port
//               req      - level jump requests, bit i = requester i
//               jval     - jump targets, requester i uses [i*WIDTH +: WIDTH]
//               gnt      - one-hot grant, high for the single LOAD cycle
//               busy     - high while the FSM is in LOAD or HOLD
//               out      - count value when ce=1, else 0
//               timeout  - one-cycle pulse when a hold times out
//
// Options     : COUNT_JUMP_HOLD_TIMEOUT_EN - when defined, a HOLD that lasts
//               16 cycles with req still high is abandoned. timeout pulses
//               and the requester is masked until its req is seen low.
//               When undefined, timeout is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module count_jump_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] jval,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [WIDTH-1:0]      out,
   output logic                  timeout
);

   localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    count;
   logic [WIDTH-1:0]    load_val;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       idx;

   logic [NREQ-1:0]     eligible;
   logic [2*NREQ-1:0]   rotated;
   logic                found;
   logic [IW:0]         sum;
   logic [IW-1:0]       pick;

`ifdef COUNT_JUMP_HOLD_TIMEOUT_EN
   logic [3:0]          hold_timer;
   logic [NREQ-1:0]     mask;

   assign eligible = req & ~mask;
`else
   assign eligible = req;
   assign timeout  = 1'b0;
`endif

   // Round-robin scan: rotate the request vector so rr_ptr lands on bit 0,
   // take the lowest set bit, then map the offset back to an absolute index.
   // The loop runs downward so the lowest set offset is the final writer.
   always_comb begin
      rotated = {eligible, eligible} >> rr_ptr;
      found   = 1'b0;
      sum     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (IW+1)'(k);
         end
      end
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      pick = sum[IW-1:0];
   end

   assign out = ce ? count : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         load_val <= '0;
         rr_ptr   <= '0;
         idx      <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
`ifdef COUNT_JUMP_HOLD_TIMEOUT_EN
         hold_timer <= '0;
         mask       <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         // Default: free-run. The LOAD branch overrides this with the target.
         count <= count + 1'b1;
         gnt   <= '0;
`ifdef COUNT_JUMP_HOLD_TIMEOUT_EN
         timeout <= 1'b0;
         // A mask bit survives only while its requester keeps req high.
         mask    <= mask & req;
`endif
         case (state)
            IDLE: begin
               if (found) begin
                  idx      <= pick;
                  load_val <= jval[pick*WIDTH +: WIDTH];
                  gnt      <= NREQ'(1) << pick;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               count  <= load_val;
               rr_ptr <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
               busy   <= 1'b1;
               state  <= HOLD;
`ifdef COUNT_JUMP_HOLD_TIMEOUT_EN
               hold_timer <= '0;
`endif
            end
            HOLD: begin
               if (!req[idx]) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
`ifdef COUNT_JUMP_HOLD_TIMEOUT_EN
               else if (hold_timer == 4'hF) begin
                  timeout <= 1'b1;
                  mask    <= (mask & req) | (NREQ'(1) << idx);
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  hold_timer <= hold_timer + 4'd1;
               end
`endif
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_count_jump_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_jump_arbiter
// Description : Self-checking bench for count_jump_arbiter (NREQ=4,
//               WIDTH=4). It combines a vector table, hand-written corner
//               sequences and randomized traffic. All outputs are compared
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_jump_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic                  clk  = 1'b0;
   logic                  rst  = 1'b1;
   logic                  ce   = 1'b1;
   logic [NREQ-1:0]       req  = '0;
   logic [NREQ*WIDTH-1:0] jval = '0;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [WIDTH-1:0]      out;
   logic                  timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   count_jump_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .req     (req),
      .jval    (jval),
      .gnt     (gnt),
      .busy    (busy),
      .out     (out),
      .timeout (timeout)
   );

   // ---------------- behavioural reference ----------------
   int m_count;
   int m_owner;
   int m_ptr;
   int m_val;
   bit m_loading;   // a load has been decided and is being granted now
   bit m_holding;   // load done, waiting for the owner to release req

   function automatic void model_reset();
      m_count   = 0;
      m_owner   = 0;
      m_ptr     = 0;
      m_val     = 0;
      m_loading = 1'b0;
      m_holding = 1'b0;
   endfunction

   function automatic void model_edge();
      int j;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_loading) begin
         m_count   = m_val;
         m_ptr     = (m_owner + 1) % NREQ;
         m_loading = 1'b0;
         m_holding = 1'b1;
      end else begin
         m_count = (m_count + 1) % 16;
         if (m_holding) begin
            if (req[m_owner] == 1'b0) m_holding = 1'b0;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (req[j]) begin
                  m_owner   = j;
                  m_val     = int'((jval >> (WIDTH * j)) & 16'hF);
                  m_loading = 1'b1;
                  break;
               end
            end
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model_gnt", 32'(gnt), m_loading ? (32'd1 << m_owner) : 32'd0);
      check("model_busy", 32'(busy), 32'(m_loading | m_holding));
      check("model_out", 32'(out), ce ? 32'(m_count) : 32'd0);
`ifndef COUNT_JUMP_HOLD_TIMEOUT_EN
      check("timeout_tied", 32'(timeout), 32'd0);
`endif
   endtask

   // One clock: the model consumes the same inputs the DUT saw at the edge,
   // outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [NREQ-1:0]  req;
      logic             ce;
      logic [NREQ-1:0]  gnt;
      logic             busy;
      logic [WIDTH-1:0] out;
   } vec_t;

   vec_t tbl[11];

   int               exp_order[6];
   int               order[$];
   int               restore;
   int               restore_cnt;
   int               cyc;
   int               gi;
   logic [NREQ-1:0]  flip;

   initial begin
      // free run from reset, single jump of requester 2 to A, ce gating, wrap
      tbl[0]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'h1};
      tbl[1]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'h2};
      tbl[2]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'h3};
      tbl[3]  = '{4'h4, 1'b1, 4'h4, 1'b1, 4'h4};
      tbl[4]  = '{4'h4, 1'b1, 4'h0, 1'b1, 4'hA};
      tbl[5]  = '{4'h4, 1'b1, 4'h0, 1'b1, 4'hB};
      tbl[6]  = '{4'h4, 1'b1, 4'h0, 1'b1, 4'hC};
      tbl[7]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'hD};
      tbl[8]  = '{4'h0, 1'b1, 4'h0, 1'b0, 4'hE};
      tbl[9]  = '{4'h0, 1'b0, 4'h0, 1'b0, 4'h0};
      tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 4'h0};
      exp_order = '{0, 1, 3, 0, 1, 3};

      model_reset();

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_out", 32'(out), 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      rst  = 1'b0;
      jval = 16'h0A00;

      // ---- table ----
      for (int i = 0; i < 11; i++) begin
         req = tbl[i].req;
         ce  = tbl[i].ce;
         step();
         check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].out));
      end

      // ---- ce gating and late jval change (rr_ptr is now 3) ----
      ce   = 1'b0;
      jval = 16'h0070;
      req  = 4'b0010;
      step();
      check("ce_gnt", 32'(gnt), 32'h2);
      check("ce_out_gated", 32'(out), 32'd0);
      jval = 16'h0030;        // must not affect the pending load
      step();                 // load edge: count becomes 7
      repeat (3) step();      // count keeps running: 10
      ce = 1'b1;
      #1;
      check("ce_advanced", 32'(out), 32'd10);
      req = 4'b0000;
      step();
      step();

      // ---- reset during LOAD (rr_ptr is now 2) ----
      jval = 16'h9000;
      req  = 4'b1000;
      step();
      check("rst_pre_gnt", 32'(gnt), 32'h8);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_gnt", 32'(gnt), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_out", 32'(out), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_regrant", 32'(gnt), 32'h8);
      step();
      check("rst_load9", 32'(out), 32'h9);
      req = 4'b0000;
      step();
      step();

      // ---- round robin with re-pulsing requesters (rr_ptr is now 0) ----
      jval        = 16'hD051;
      req         = 4'b1011;
      restore     = 0;
      restore_cnt = 0;
      cyc         = 0;
      while (order.size() < 6 && cyc < 80) begin
         step();
         cyc++;
         if (restore_cnt > 0) begin
            restore_cnt--;
            if (restore_cnt == 1)
               check("rr_load_val", 32'(out), 32'((jval >> (WIDTH * restore)) & 16'hF));
            if (restore_cnt == 0) req[restore] = 1'b1;
         end
         if (gnt != '0) begin
            gi = 0;
            for (int b = NREQ - 1; b >= 0; b--) if (gnt[b]) gi = b;
            order.push_back(gi);
            req[gi]     = 1'b0;
            restore     = gi;
            restore_cnt = 2;
         end
      end
      check("rr_grant_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < order.size())
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      end
      req = 4'b0000;
      step();
      step();

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(99) == 0) begin
            rst = 1'b1;
            model_reset();
            step();
            rst = 1'b0;
         end
         for (int b = 0; b < NREQ; b++) flip[b] = ($urandom_range(3) == 0);
         req  = req ^ flip;
         jval = 16'($urandom);
         ce   = ($urandom_range(4) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
